// File: rtl/binary_frame_server.sv
// Binarizes one streamed luma frame into a 1-bpp buffer and serves 2-cycle-latency pixel reads.
// Optional: define ADAPTIVE_THRESH_EN to derive the next capture's threshold from the mean luma.
module binary_frame_server #(
  parameter int unsigned WIDTH     = 480,
  parameter int unsigned HEIGHT    = 480,
  parameter logic [7:0]  THRESHOLD = 8'd128
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        pix_valid_in,
  input  logic [8:0]  pix_x_in,
  input  logic [8:0]  pix_y_in,
  input  logic [7:0]  pix_luma_in,
  input  logic        capture_start,
  input  logic [19:0] address_reading,
  output logic        pixel_reading,
  output logic        frame_valid,
  output logic        frame_done
);

  localparam int unsigned AW    = 20;
  localparam int unsigned DEPTH = WIDTH * HEIGHT;
  localparam int unsigned MW    = $clog2(DEPTH);
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
  localparam logic [8:0]    X_LAST  = 9'(WIDTH - 1);
  localparam logic [8:0]    Y_LAST  = 9'(HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_FILLING, S_READY} state_t;

  state_t          state;
  state_t          state_next;
  logic            wr_en;
  logic            done_next;
  logic            in_range;
  logic            at_origin;
  logic            at_last;
  logic            wr_bit;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   rd_addr_q;
  logic [7:0]      thr;
  logic            mem [DEPTH];

  // Sample decode: bounds, corner detection, linear address and binarized bit.
  always_comb begin
    in_range  = (32'(pix_x_in) < WIDTH) && (32'(pix_y_in) < HEIGHT);
    at_origin = (pix_x_in == 9'd0) && (pix_y_in == 9'd0);
    at_last   = (pix_x_in == X_LAST) && (pix_y_in == Y_LAST);
    wr_addr   = AW'(pix_x_in) + AW'(pix_y_in) * AW'(WIDTH);
    wr_bit    = (pix_luma_in >= thr);
  end

  // Capture control: arm, fill from the origin, freeze on the last pixel.
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    done_next  = 1'b0;
    case (state)
      S_IDLE: begin
        if (capture_start) state_next = S_ARMED;
      end
      S_ARMED: begin
        if (pix_valid_in && at_origin) begin
          wr_en      = 1'b1;
          state_next = S_FILLING;
        end
      end
      S_FILLING: begin
        if (pix_valid_in && in_range) begin
          wr_en = 1'b1;
          if (at_last) begin
            state_next = S_READY;
            done_next  = 1'b1;
          end
        end
      end
      S_READY: begin
        if (capture_start) state_next = S_ARMED;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= S_IDLE;
      frame_valid <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_next;
      frame_valid <= (state_next == S_READY);
      frame_done  <= done_next;
    end
  end

  // Frame buffer is never cleared; a write during reset is suppressed.
  always_ff @(posedge clk_in) begin
    if (wr_en && !rst_in) mem[MW'(wr_addr)] <= wr_bit;
  end

  // Two-stage read pipeline; out-of-frame addresses read as white.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_addr_q     <= '1;
      pixel_reading <= 1'b1;
    end else begin
      rd_addr_q     <= address_reading;
      pixel_reading <= (rd_addr_q < DEPTH_A) ? mem[MW'(rd_addr_q)] : 1'b1;
    end
  end

`ifdef ADAPTIVE_THRESH_EN
  localparam int unsigned SW = 24;
  logic [SW-1:0] luma_sum;
  logic [SW-1:0] sum_next;

  // Accumulate luma over the top-left 256x256 window of the frame being written.
  always_comb begin
    sum_next = luma_sum;
    if (wr_en && !pix_x_in[8] && !pix_y_in[8]) sum_next = luma_sum + SW'(pix_luma_in);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      luma_sum <= '0;
      thr      <= THRESHOLD;
    end else begin
      if ((state_next == S_ARMED) && (state != S_ARMED)) luma_sum <= '0;
      else                                                luma_sum <= sum_next;
      if (done_next) thr <= sum_next[23:16];
    end
  end
`else
  assign thr = THRESHOLD;
`endif

endmodule

// File: tb/tb_binary_frame_server.sv
// Directed bench for binary_frame_server: a spec-level model (sparse frames, associative memory)
// is compared every cycle, plus literal expectations for the key pixels and pulses.
module tb_binary_frame_server;

  localparam int W     = 480;
  localparam int H     = 480;
  localparam int DEPTH = W * H;
  localparam int THR0  = 128;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        pix_valid_in;
  logic [8:0]  pix_x_in;
  logic [8:0]  pix_y_in;
  logic [7:0]  pix_luma_in;
  logic        capture_start;
  logic [19:0] address_reading;
  logic        pixel_reading;
  logic        frame_valid;
  logic        frame_done;

  binary_frame_server dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .pix_valid_in    (pix_valid_in),
    .pix_x_in        (pix_x_in),
    .pix_y_in        (pix_y_in),
    .pix_luma_in     (pix_luma_in),
    .capture_start   (capture_start),
    .address_reading (address_reading),
    .pixel_reading   (pixel_reading),
    .frame_valid     (frame_valid),
    .frame_done      (frame_done)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  bit chk_en   = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_ARMED, M_FILLING, M_READY} mode_t;
  mode_t m_mode = M_IDLE;
  bit    m_mem [int];
  int    m_thr = THR0;
  int    m_sum = 0;
  int    prev_addr = 0;
  bit    prev_known = 0;
  logic  exp_pix = 1'b1;
  bit    exp_pix_known = 0;
  logic  exp_valid = 1'b0;
  logic  exp_done = 1'b0;

  function automatic void m_write(input int x, input int y, input int luma);
    m_mem[x + y * W] = (luma >= m_thr);
`ifdef ADAPTIVE_THRESH_EN
    if (x < 256 && y < 256) m_sum += luma;
`endif
  endfunction

  always @(posedge clk_in) begin
    int x, y;
    x = int'(pix_x_in);
    y = int'(pix_y_in);
    if (rst_in) begin
      m_mode = M_IDLE; exp_valid = 0; exp_done = 0;
      exp_pix = 1; exp_pix_known = 1; prev_known = 0;
      m_thr = THR0; m_sum = 0;
    end else begin
      // read sees memory contents from before this edge's write
      if (!prev_known) exp_pix_known = 0;
      else if (prev_addr >= DEPTH) begin exp_pix = 1; exp_pix_known = 1; end
      else if (m_mem.exists(prev_addr)) begin exp_pix = m_mem[prev_addr]; exp_pix_known = 1; end
      else exp_pix_known = 0;
      exp_done = 0;
      case (m_mode)
        M_IDLE:  if (capture_start) begin m_mode = M_ARMED; m_sum = 0; end
        M_ARMED: if (pix_valid_in && x == 0 && y == 0) begin m_write(x, y, int'(pix_luma_in)); m_mode = M_FILLING; end
        M_FILLING: if (pix_valid_in && x < W && y < H) begin
          m_write(x, y, int'(pix_luma_in));
          if (x == W - 1 && y == H - 1) begin
            m_mode = M_READY; exp_done = 1;
`ifdef ADAPTIVE_THRESH_EN
            m_thr = m_sum / 65536;
`endif
          end
        end
        M_READY: if (capture_start) begin m_mode = M_ARMED; m_sum = 0; end
      endcase
      exp_valid = (m_mode == M_READY);
      prev_addr = int'(address_reading);
      prev_known = 1;
    end
  end

  // Compare process.
  always @(negedge clk_in) begin
    if (chk_en) begin
      chk("frame_valid", frame_valid, exp_valid);
      chk("frame_done", frame_done, exp_done);
      if (exp_pix_known) chk("pixel_reading", pixel_reading, exp_pix);
    end
    if (frame_done === 1'b1) n_done++;
  end

  // ---------------- stimulus ----------------
  task automatic send(input int x, input int y, input int luma);
    pix_valid_in = 1'b1;
    pix_x_in     = 9'(x);
    pix_y_in     = 9'(y);
    pix_luma_in  = 8'(luma);
    @(negedge clk_in);
    pix_valid_in = 1'b0;
  endtask

  task automatic pulse_capture();
    capture_start = 1'b1;
    @(negedge clk_in);
    capture_start = 1'b0;
  endtask

  task automatic read_lit(input string name, input int addr, input logic exp);
    address_reading = 20'(addr);
    @(negedge clk_in);
    @(negedge clk_in);
    chk(name, pixel_reading, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  initial begin
    rst_in = 1'b1; pix_valid_in = 1'b0; pix_x_in = '0; pix_y_in = '0;
    pix_luma_in = '0; capture_start = 1'b0; address_reading = '0;
    @(negedge clk_in);
    chk_en = 1;
    idle(2);
    chk("reset_frame_valid", frame_valid, 1'b0);
    chk("reset_pixel", pixel_reading, 1'b1);
    chk("reset_frame_done", frame_done, 1'b0);
    rst_in = 1'b0;
    idle(3);

    // Frame 1: sparse capture with threshold boundaries and a dropped sample.
    pulse_capture();
    pulse_capture();            // ignored while armed
    send(5, 5, 255);            // not the origin: ignored while armed
    send(0, 0, 50);
    send(1, 0, 50);
    send(2, 0, 50);
    send(3, 0, 128);
    send(4, 0, 127);
    pix_x_in = 9'd1; pix_y_in = 9'd0; pix_luma_in = 8'd255;
    @(negedge clk_in);          // invalid cycle must not write
    send(10, 6, 50);
    send(490, 5, 200);          // out of range: would alias address 2890
    pulse_capture();            // ignored while filling
    send(10, 20, 200);
    send(11, 20, 50);
    send(479, 479, 50);
    idle(2);
    chk_int("done_count_frame1", n_done, 1);
    chk("frame_valid_after_frame1", frame_valid, 1'b1);
    read_lit("addr_9610", 9610, 1'b1);
    read_lit("addr_0", 0, 1'b0);
    read_lit("addr_3_thr_equal", 3, 1'b1);
    read_lit("addr_4_thr_below", 4, 1'b0);
    read_lit("addr_1_invalid_ignored", 1, 1'b0);
    read_lit("addr_2890_drop", 2890, 1'b0);

    // Back-to-back reads: one result per cycle, two cycles after each address.
    address_reading = 20'd3; @(negedge clk_in);
    address_reading = 20'd4; @(negedge clk_in);
    chk("b2b_0", pixel_reading, 1'b1);
    address_reading = 20'd9610; @(negedge clk_in);
    chk("b2b_1", pixel_reading, 1'b0);
    address_reading = 20'd0; @(negedge clk_in);
    chk("b2b_2", pixel_reading, 1'b1);
    @(negedge clk_in);
    chk("b2b_3", pixel_reading, 1'b0);

    // Writes while READY are ignored.
    send(0, 0, 255);
    send(4, 0, 255);
    send(479, 479, 255);
    idle(2);
    chk("ready_frame_valid", frame_valid, 1'b1);
    chk_int("ready_no_done", n_done, 1);
    read_lit("ready_addr_0", 0, 1'b0);
    read_lit("ready_addr_4", 4, 1'b0);

    // Out-of-frame addresses.
    read_lit("addr_230400", 230400, 1'b1);
    read_lit("addr_fffff", 'hFFFFF, 1'b1);
    read_lit("addr_230399", 230399, 1'b0);

    // Recapture with a mid-fill restart at the origin.
    pulse_capture();
    chk("recapture_valid_drop", frame_valid, 1'b0);
    send(0, 0, 50);
    send(1, 0, 200);
    send(0, 0, 200);
    send(479, 479, 200);
    idle(2);
    chk_int("done_count_frame2", n_done, 2);
    read_lit("restart_addr_0", 0, 1'b1);
    read_lit("restart_addr_1", 1, 1'b1);

    // Reset in the middle of a fill.
    pulse_capture();
    send(0, 0, 0);
    for (int i = 0; i < 240; i++) send(i, 1, 0);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    chk("midfill_reset_valid", frame_valid, 1'b0);
    chk("midfill_reset_pixel", pixel_reading, 1'b1);
    send(479, 479, 0);
    idle(3);
    chk_int("midfill_no_done", n_done, 2);
    chk("midfill_idle_valid", frame_valid, 1'b0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
